// File: rtl/usb_ft1248_device.sv
// FT1248 4-bit slave: decodes command nibbles, answers ACK/NAK on usb_miso and
// moves data bytes between the bus and the h2d sink / d2h show-ahead source.
module usb_ft1248_device #(
  parameter logic [7:0] CMD_WRITE = 8'h00,
  parameter logic [7:0] CMD_READ  = 8'h04,
  parameter logic [7:0] CMD_FORCE = 8'h80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       usb_clk,
  input  logic       usb_cs,
  output logic       usb_miso,
  input  logic [3:0] usb_miosi_in,
  output logic [3:0] usb_miosi_out,
  output logic       usb_miosi_oe,
  input  logic       h2d_full,
  output logic       h2d_write,
  output logic [7:0] h2d_wdata,
  input  logic       d2h_empty,
  output logic       d2h_read,
  input  logic [7:0] d2h_rdata,
  output logic       force_event
);

  typedef enum logic [2:0] {IDLE, CMD_HI, CMD_LO, STATUS, WRITE_DATA, READ_DATA} state_t;

  state_t     state, state_d;
  logic       s_clk, p_clk, s_cs;
  logic [3:0] s_miosi;
  logic       rise, fall;
  logic [1:0] nib, nib_d;
  logic [7:0] cmd, cmd_d;
  logic       stat_done, done_d;
  logic       miso_d, oe_d, write_d, read_d, force_d;
  logic [3:0] out_d;
  logic [7:0] wdata_d;

  assign rise = s_clk & ~p_clk;
  assign fall = ~s_clk & p_clk;

  // Every byte is followed by a STATUS slot (falling edge reports, rising edge
  // exits), so a data byte costs three usb_clk periods including its status.
  always_comb begin
    state_d = state;
    nib_d   = nib;
    cmd_d   = cmd;
    done_d  = stat_done;
    miso_d  = usb_miso;
    out_d   = usb_miosi_out;
    oe_d    = usb_miosi_oe;
    wdata_d = h2d_wdata;
    write_d = 1'b0;
    read_d  = 1'b0;
    force_d = 1'b0;
    if (s_cs) begin
      state_d = IDLE;
      nib_d   = 2'd0;
      cmd_d   = 8'h00;
      done_d  = 1'b0;
      miso_d  = 1'b1;
      out_d   = 4'hF;
      oe_d    = 1'b0;
    end else begin
      case (state)
        IDLE: state_d = CMD_HI;
        CMD_HI: if (rise) begin
          cmd_d[7:4] = s_miosi;
          state_d    = CMD_LO;
        end
        CMD_LO: if (rise) begin
          cmd_d[3:0] = s_miosi;
          done_d     = 1'b0;
          state_d    = STATUS;
        end
        STATUS: begin
          if (fall && !stat_done) begin
            done_d = 1'b1;
            miso_d = 1'b1;
            oe_d   = 1'b0;
            out_d  = 4'hF;
            if (cmd == CMD_WRITE) begin
              miso_d = h2d_full;
            end else if (cmd == CMD_READ) begin
              if (!d2h_empty) begin
                miso_d = 1'b0;
                oe_d   = 1'b1;
                out_d  = d2h_rdata[3:0];
              end
            end else if (cmd == CMD_FORCE) begin
              force_d = 1'b1;
            end
          end else if (rise && stat_done && !usb_miso) begin
            nib_d   = 2'd0;
            state_d = (cmd == CMD_READ) ? READ_DATA : WRITE_DATA;
          end
        end
        WRITE_DATA: if (rise) begin
          if (nib == 2'd0) begin
            wdata_d[3:0] = s_miosi;
            nib_d        = 2'd1;
          end else begin
            wdata_d[7:4] = s_miosi;
            write_d      = !h2d_full;
            done_d       = 1'b0;
            state_d      = STATUS;
          end
        end
        READ_DATA: begin
          if (fall && nib == 2'd0) begin
            out_d = d2h_rdata[3:0];
            nib_d = 2'd1;
          end else if (fall && nib == 2'd1) begin
            out_d = d2h_rdata[7:4];
            nib_d = 2'd2;
          end else if (rise && nib == 2'd2) begin
            read_d  = 1'b1;
            done_d  = 1'b0;
            state_d = STATUS;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_clk         <= 1'b0;
      p_clk         <= 1'b0;
      s_cs          <= 1'b1;
      s_miosi       <= 4'h0;
      state         <= IDLE;
      nib           <= 2'd0;
      cmd           <= 8'h00;
      stat_done     <= 1'b0;
      usb_miso      <= 1'b1;
      usb_miosi_out <= 4'hF;
      usb_miosi_oe  <= 1'b0;
      h2d_write     <= 1'b0;
      h2d_wdata     <= 8'h00;
      d2h_read      <= 1'b0;
      force_event   <= 1'b0;
    end else begin
      s_clk         <= usb_clk;
      p_clk         <= s_clk;
      s_cs          <= usb_cs;
      s_miosi       <= usb_miosi_in;
      state         <= state_d;
      nib           <= nib_d;
      cmd           <= cmd_d;
      stat_done     <= done_d;
      usb_miso      <= miso_d;
      usb_miosi_out <= out_d;
      usb_miosi_oe  <= oe_d;
      h2d_write     <= write_d;
      h2d_wdata     <= wdata_d;
      d2h_read      <= read_d;
      force_event   <= force_d;
    end
  end

endmodule

// File: doc/usb_ft1248_device.md
Name: usb_ft1248_device

Overview:
- Synthesizable FT1248 4-bit slave: the FTDI-side responder to the host-side FT1248 master.
- Decodes command nibbles, returns ACK/NAK on usb_miso, and moves data bytes between the bus and two FIFO-style handshake ports.
- Used as a loopback/bench partner for the USB controller and as a device-side endpoint in test builds.
- Runs in the system clock domain; bus inputs are oversampled.

Parameters:
- CMD_WRITE, 8'h00, command code for master→device data.
- CMD_READ, 8'h04, command code for device→master data.
- CMD_FORCE, 8'h80, send-immediate command code; never acknowledged.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- usb_clk  in  1  FT1248 clock from master.
- usb_cs  in  1  FT1248 chip select, active low.
- usb_miso  out  1  status: 0 = ACK, 1 = NAK/idle.
- usb_miosi_in  in  4  data nibble from master.
- usb_miosi_out  out  4  data nibble to master.
- usb_miosi_oe  out  1  device drives miosi.
- h2d_full  in  1  host-to-device sink full.
- h2d_write  out  1  one-cycle push strobe.
- h2d_wdata  out  8  byte pushed.
- d2h_empty  in  1  device-to-host source empty.
- d2h_read  out  1  one-cycle pop strobe; d2h_rdata is show-ahead.
- d2h_rdata  in  8  byte at head of source.
- force_event  out  1  one-cycle pulse on CMD_FORCE decode.

Behaviour:
- Input sampling:
  - usb_clk, usb_cs and usb_miosi_in are registered once; rise/fall are detected against the previous registered value.
  - All outputs are registered. Output changes land exactly 2 clk cycles after a falling usb_clk edge at the pin.
- Reset (or usb_cs high) forces:
  - state IDLE, usb_miso=1, usb_miosi_oe=0, usb_miosi_out=4'hF;
  - h2d_write=0, d2h_read=0, force_event=0.
  - Any partial byte or nibble is discarded.
- States: IDLE, CMD_HI, CMD_LO, STATUS, WRITE_DATA, READ_DATA.
- IDLE → CMD_HI when registered usb_cs is low.
- CMD_HI: first rising edge latches cmd[7:4] → CMD_LO.
- CMD_LO: next rising edge latches cmd[3:0] → STATUS.
- STATUS, on the next falling edge, drive usb_miso:
  - CMD_WRITE: 0 if !h2d_full, else 1.
  - CMD_READ: 0 if !d2h_empty, else 1. When ACKing, also set usb_miosi_oe=1 and usb_miosi_out=d2h_rdata[3:0].
  - CMD_FORCE: 1, and pulse force_event.
  - Any other code: 1.
- STATUS exit, on the next rising edge:
  - ACK → WRITE_DATA or READ_DATA with nibble index 0.
  - NAK → hold usb_miso=1 until usb_cs high, then IDLE.
- WRITE_DATA:
  - Rising edge, nibble 0: latch h2d_wdata[3:0].
  - Rising edge, nibble 1: latch h2d_wdata[7:4] and pulse h2d_write one cycle later. The push is suppressed if h2d_full.
  - Falling edge after nibble 1: usb_miso = h2d_full evaluated after the push. If 1, stay NAK until cs high.
- READ_DATA:
  - Falling edge, nibble 0: drive d2h_rdata[3:0].
  - Falling edge, nibble 1: drive d2h_rdata[7:4].
  - Rising edge after nibble 1: pulse d2h_read one cycle.
  - Next falling edge: usb_miso = d2h_empty after the pop. If 1, release miosi (oe=0) and stay NAK.
- Byte order is low nibble first for data; command is high nibble first.
- usb_cs rising at any point returns to IDLE with no further strobes. A byte is committed only after both nibbles.
- Simultaneous cs rise and a rising usb_clk in the same sample: cs wins, no strobe.
- Never more than one h2d_write or d2h_read per byte. Strobes never occur outside their own state.

Test Plan:
1. CMD_WRITE with h2d_full=0, master sends bytes 0xA5, 0x3C → miso 0 at status; h2d_write pulses twice with h2d_wdata 0xA5 then 0x3C.
2. CMD_READ with source {0x12, 0x34} then empty → miosi nibbles 2,1,4,3; two d2h_read pulses; miso=1 after the second byte; oe drops.
3. CMD_READ with d2h_empty=1 → miso=1 at status; no d2h_read; miosi_oe stays 0.
4. CMD_FORCE (0x80) → force_event exactly one cycle; miso=1; no data strobes.
5. CMD_WRITE, h2d_full rises after the first byte → first byte pushed; miso=1 at the next falling edge; a second byte sent anyway is not pushed.
6. cs deasserted after one data nibble; reset_n low mid-READ → no strobes; all outputs at reset values next cycle; next transaction decodes normally.
